pipe_skip_adder: RTL and testbench
==================================

# pipe_skip_adder

Parametrised, pipelined carry-skip adder with a valid/ready stream interface. It is the next-generation replacement for the fixed 16-bit, 4-bit-block combinational carry-skip adder in the adder lab library. Each BLK-bit block sits in its own pipeline stage, so the block sustains one addition per cycle at a clock rate set by one block rather than the full width. Downstream stalls propagate back through the pipeline without losing or duplicating data.

## Interface
Parameters:
- WIDTH, 16, operand/sum width; must be an integer multiple of BLK, and WIDTH >= BLK
- BLK, 4, bits per carry-skip block; NB = WIDTH/BLK is both the stage count and the latency

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operand beat present
- in_ready  out  1  stage 0 can accept a beat
- a  in  WIDTH  operand A, unsigned or two's complement
- b  in  WIDTH  operand B
- cin  in  1  carry into bit 0
- sub  in  1  subtract select; present only when SKIP_ADD_SUB_EN is defined
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  result
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow, equal to carry into the MSB XOR carry out of the MSB

## Operation
- Stage k (k = 0..NB-1) holds a valid bit, the running carry, and the sum bits finished so far. It also holds the unprocessed operand slices of blocks k..NB-1, which are skewed forward with the beat.
- Block computation in stage k:
  - per-bit propagate p = a^b and generate g = a&b
  - ripple carry across the block
  - block propagate P = AND of the block's p bits
  - block carry-out = P ? carry-in : ripple carry-out
  - The skip condition must use p (a^b), never the partial sum.
- Carry into block 0 is cin, or (cin|sub) when subtraction is compiled in.
- The final stage produces sum, cout, and ovf. ovf uses the carry into bit WIDTH-1, captured in the last stage.
- Handshake:
  - A beat transfers on an edge where valid and ready are both high.
  - Stage k advances when it is empty or stage k+1 (or the output, for the last stage) accepts.
  - in_ready = ~v[0] | advance[0], and is combinational from out_ready through the chain.
  - While out_valid is high and out_ready is low, out_valid, sum, cout, and ovf are held stable.
- Reset: every valid bit is cleared. out_valid=0, in_ready=1 in the cycle after reset, sum=0, cout=0, ovf=0. Data registers are cleared as well. A beat presented in the same cycle as rst is dropped.
- Reset mid-operation discards all in-flight beats. No result for them ever appears.
- Arithmetic is modulo 2^WIDTH. The carry out of the top bit appears only on cout, with no internal width growth.

## Timing
- Latency is NB cycles. A beat accepted at edge t shows out_valid=1 after edge t+NB-1 when there are no stalls. WIDTH=16 and BLK=4 give 4 cycles.
- Throughput is 1 beat per cycle with out_ready held high. There are no bubbles when in_valid is held high.
- A stall of S cycles at the output delays every queued beat by exactly S cycles. The pipeline holds up to NB beats before in_ready falls.
- Simultaneous accept at the input and drain at the output while full is legal and keeps occupancy constant.
- The critical path is one BLK-bit ripple plus the skip mux, independent of WIDTH.

## Configuration
- SKIP_ADD_SUB_EN
  - Defined: the sub port exists. It travels with the beat, and b is XORed with sub before stage 0, giving a - b when sub=1 and cin=0. ovf then reports signed subtraction overflow.
  - Not defined: there is no sub port and the block adds only. Behaviour is identical to the defined case with sub=0.

## Test plan
All cases use WIDTH=16 and BLK=4.
1. Reset, then a=16'h1234, b=16'h1111, cin=0 -> after 4 cycles sum=16'h2345, cout=0, ovf=0. All outputs are 0 while rst is high.
2. Full skip: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1. Also a=16'h7FFF, b=16'h0001 -> sum=16'h8000, ovf=1, cout=0.
3. Back-to-back stream of 8 random beats with in_valid and out_ready held high -> 8 consecutive out_valid cycles starting 4 cycles after the first accept. Results must match a reference model in order.
4. Backpressure: fill with 6 beats while out_ready=0 -> in_ready drops after 4 beats accepted and sum stays stable. Releasing out_ready drains in order with no loss or duplication.
5. Assert rst for one cycle with 3 beats in flight -> out_valid=0 the next cycle, and none of the 3 results ever appears. A new beat afterwards completes normally.
6. With SKIP_ADD_SUB_EN defined: sub=1, a=16'h0005, b=16'h0007, cin=0 -> sum=16'hFFFE, cout=0. Also sub=1, a=16'h8000, b=16'h0001 -> ovf=1.

Source files
------------

// File: rtl/pipe_skip_adder.sv
// rtl/pipe_skip_adder.sv - pipelined carry-skip adder, one BLK-bit block per stage, valid/ready stream
// Optional subtract path compiled in when SKIP_ADD_SUB_EN is defined.
module pipe_skip_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SKIP_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NB = WIDTH / BLK;

  logic [NB-1:0]    v_q;
  logic [NB-1:0]    c_q, c_d;
  logic [NB-1:0]    adv;
  logic             cmsb_q, cmsb_d;
  logic [WIDTH-1:0] a_q [NB];
  logic [WIDTH-1:0] b_q [NB];
  logic [WIDTH-1:0] s_q [NB];
  logic [WIDTH-1:0] a_d [NB];
  logic [WIDTH-1:0] b_d [NB];
  logic [WIDTH-1:0] s_d [NB];

  logic [WIDTH-1:0] b_in;
  logic             c_in0;

`ifdef SKIP_ADD_SUB_EN
  assign b_in  = b ^ {WIDTH{sub}};
  assign c_in0 = cin | sub;
`else
  assign b_in  = b;
  assign c_in0 = cin;
`endif

  // A stage may load when it is empty or everything ahead of it moves this edge.
  always_comb begin
    logic r;
    r   = out_ready;
    adv = '0;
    for (int k = NB - 1; k >= 0; k--) begin
      adv[k] = ~v_q[k] | r;
      r      = adv[k];
    end
  end

  assign in_ready = adv[0] & ~rst;

  always_comb begin
    logic [WIDTH-1:0] av, bv, sv;
    logic             ci, c, pall, p, g;
    int               km1, idx;
    a_d    = '{default: '0};
    b_d    = '{default: '0};
    s_d    = '{default: '0};
    c_d    = '0;
    cmsb_d = 1'b0;
    for (int k = 0; k < NB; k++) begin
      km1  = (k == 0) ? 0 : k - 1;
      av   = (k == 0) ? a     : a_q[km1];
      bv   = (k == 0) ? b_in  : b_q[km1];
      sv   = (k == 0) ? '0    : s_q[km1];
      ci   = (k == 0) ? c_in0 : c_q[km1];
      c    = ci;
      pall = 1'b1;
      for (int i = 0; i < BLK; i++) begin
        idx     = k * BLK + i;
        p       = av[idx] ^ bv[idx];
        g       = av[idx] & bv[idx];
        sv[idx] = p ^ c;
        if (idx == WIDTH - 1) cmsb_d = c;
        c       = g | (p & c);
        pall    = pall & p;
      end
      a_d[k] = av;
      b_d[k] = bv;
      s_d[k] = sv;
      // Skip decision uses the block propagate, so the carry bypasses the ripple.
      c_d[k] = pall ? ci : c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      c_q    <= '0;
      cmsb_q <= 1'b0;
      for (int k = 0; k < NB; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (adv[k]) begin
          v_q[k] <= (k == 0) ? in_valid : v_q[(k == 0) ? 0 : k - 1];
          c_q[k] <= c_d[k];
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
        end
      end
      if (adv[NB-1]) cmsb_q <= cmsb_d;
    end
  end

  assign out_valid = v_q[NB-1];
  assign sum       = s_q[NB-1];
  assign cout      = c_q[NB-1];
  assign ovf       = c_q[NB-1] ^ cmsb_q;

endmodule

// File: tb/tb_pipe_skip_adder.sv
// tb/tb_pipe_skip_adder.sv - self-checking bench for pipe_skip_adder against an arithmetic reference queue
// Subtract steps run only when SKIP_ADD_SUB_EN is defined.
module tb_pipe_skip_adder;
  localparam int W  = 16;
  localparam int B  = 4;
  localparam int NB = W / B;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, cin, sub_v;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;
  logic         took;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  int last_pop = 0;
  int n;

  typedef struct {
    logic [W+1:0] res;
    int           acc;
  } beat_t;
  beat_t q[$];

  always #5 clk = ~clk;

  pipe_skip_adder #(.WIDTH(W), .BLK(B)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef SKIP_ADD_SUB_EN
    .sub      (sub_v),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
    logic [W-1:0] yy;
    logic [W:0]   t;
    logic         ov;
    yy = sb ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (ci | sb)};
    ov = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return {ov, t[W], t[W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the queue, then account for the edge.
  task automatic tick(output logic acc_o);
    logic exp_v, exp_rdy, drn;
    int   due;
    beat_t e;
    #1;
    due = 0;
    if (q.size() > 0) due = (q[0].acc + NB - 1 > last_pop) ? q[0].acc + NB - 1 : last_pop;
    exp_v   = (q.size() > 0) && (ecount >= due);
    exp_rdy = !rst && (out_ready || q.size() < NB);
    chk("out_valid", 64'(out_valid), 64'(exp_v));
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (out_valid && q.size() > 0) chk("result", 64'({ovf, cout, sum}), 64'(q[0].res));
    acc_o = in_valid && exp_rdy;
    drn   = exp_v && out_ready;
    e.res = model(a, b, cin, sub_v);
    @(posedge clk);
    ecount++;
    if (rst) begin
      q.delete();
    end else begin
      if (drn) begin
        void'(q.pop_front());
        last_pop = ecount;
      end
      if (acc_o) begin
        e.acc = ecount;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic beat(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
    a = x; b = y; cin = ci; sub_v = sb; in_valid = 1'b1;
  endtask

  task automatic idle(input int cyc);
    in_valid = 1'b0;
    for (int i = 0; i < cyc; i++) tick(took);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub_v = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    tick(took);
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    rst = 1'b0;
    tick(took);

    // directed additions
    beat(16'h1234, 16'h1111, 1'b0, 1'b0); tick(took);
    idle(NB + 1);
    beat(16'hFFFF, 16'h0000, 1'b1, 1'b0); tick(took);
    beat(16'h7FFF, 16'h0001, 1'b0, 1'b0); tick(took);
    idle(NB + 1);

    // back-to-back random stream
    for (int i = 0; i < 8; i++) begin
      beat(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      tick(took);
    end
    idle(NB + 2);

    // backpressure: fill past capacity, then release
    out_ready = 1'b0;
    n = 0;
    beat(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(took);
      if (took) begin
        n++;
        beat(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      end
    end
    chk("fill_count", 64'(n), 64'(NB));
    out_ready = 1'b1;
    for (int i = 0; i < 20 && n < 6; i++) begin
      tick(took);
      if (took) begin
        n++;
        beat(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      end
    end
    chk("fill_total", 64'(n), 64'(6));
    idle(NB + 4);

    // random valid / ready mix
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || took) begin
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      end
      tick(took);
    end
    out_ready = 1'b1;
    idle(NB + 8);

    // reset with beats in flight
    for (int i = 0; i < 3; i++) begin
      beat(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      tick(took);
    end
    rst = 1'b1;
    beat(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    tick(took);
    rst = 1'b0;
    in_valid = 1'b0;
    idle(NB + 2);
    beat(16'h00FF, 16'h0001, 1'b0, 1'b0); tick(took);
    idle(NB + 1);

`ifdef SKIP_ADD_SUB_EN
    beat(16'h0005, 16'h0007, 1'b0, 1'b1); tick(took);
    beat(16'h8000, 16'h0001, 1'b0, 1'b1); tick(took);
    for (int i = 0; i < 6; i++) begin
      beat(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      tick(took);
    end
    sub_v = 1'b0;
    idle(NB + 2);
`endif

    chk("drained", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
